// File: rtl/rect_fill_engine_if.sv
// Command and pixel-write port bundle between a command source and rect_fill_engine.
// master drives commands and consumes status/pixels; slave is the engine side.
interface rect_fill_engine_if;
    logic        START;
    logic [7:0]  X0;
    logic [7:0]  Y0;
    logic [7:0]  X1;
    logic [7:0]  Y1;
    logic [11:0] COLOUR;
    logic        OUTLINE;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  OUT_X;
    logic [7:0]  OUT_Y;
    logic        OUT_WR;
    logic [11:0] OUT_RGB;

    modport master (
        output START, X0, Y0, X1, Y1, COLOUR, OUTLINE,
        input  BUSY, DONE, OUT_X, OUT_Y, OUT_WR, OUT_RGB
    );

    modport slave (
        input  START, X0, Y0, X1, Y1, COLOUR, OUTLINE,
        output BUSY, DONE, OUT_X, OUT_Y, OUT_WR, OUT_RGB
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: normalises/clips a corner pair and emits one raster-order pixel write per clock.
// Optional border-only drawing is enabled by defining RECT_OUTLINE_EN.
module rect_fill_engine #(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic               CLOCK_25,
    input  logic               RESET_N,
    rect_fill_engine_if.slave  bus
);

    localparam logic [7:0] X_LIM  = 8'(SCR_W);
    localparam logic [7:0] Y_LIM  = 8'(SCR_H);
    localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
    localparam logic [7:0] Y_LAST = 8'(SCR_H - 1);

`ifdef RECT_OUTLINE_EN
    localparam logic OUTLINE_FEATURE = 1'b1;
`else
    localparam logic OUTLINE_FEATURE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_x0_q, cmd_x0_d;
    logic [7:0]  cmd_y0_q, cmd_y0_d;
    logic [7:0]  cmd_x1_q, cmd_x1_d;
    logic [7:0]  cmd_y1_q, cmd_y1_d;
    logic [11:0] colour_q, colour_d;
    logic        outline_q, outline_d;
    logic [7:0]  xmin_q, xmin_d;
    logic [7:0]  xmax_q, xmax_d;
    logic [7:0]  ymin_q, ymin_d;
    logic [7:0]  ymax_q, ymax_d;
    logic [7:0]  out_x_q, out_x_d;
    logic [7:0]  out_y_q, out_y_d;
    logic [11:0] out_rgb_q, out_rgb_d;
    logic        out_wr_q, out_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  norm_xmin_s, norm_xmax_s, norm_ymin_s, norm_ymax_s;
    logic [7:0]  clip_xmax_s, clip_ymax_s;
    logic        empty_s;
    logic        mask_en_s;
    logic        last_col_s, last_pix_s;
    logic [7:0]  next_x_s, next_y_s;

    function automatic logic on_border(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] x_lo, input logic [7:0] x_hi,
                                       input logic [7:0] y_lo, input logic [7:0] y_hi);
        return (x == x_lo) || (x == x_hi) || (y == y_lo) || (y == y_hi);
    endfunction

    assign norm_xmin_s = (cmd_x0_q <= cmd_x1_q) ? cmd_x0_q : cmd_x1_q;
    assign norm_xmax_s = (cmd_x0_q <= cmd_x1_q) ? cmd_x1_q : cmd_x0_q;
    assign norm_ymin_s = (cmd_y0_q <= cmd_y1_q) ? cmd_y0_q : cmd_y1_q;
    assign norm_ymax_s = (cmd_y0_q <= cmd_y1_q) ? cmd_y1_q : cmd_y0_q;
    assign clip_xmax_s = (norm_xmax_s > X_LAST) ? X_LAST : norm_xmax_s;
    assign clip_ymax_s = (norm_ymax_s > Y_LAST) ? Y_LAST : norm_ymax_s;
    assign empty_s     = (norm_xmin_s >= X_LIM) || (norm_ymin_s >= Y_LIM);

    // Outline masking only takes effect when the feature is built in.
    assign mask_en_s   = outline_q & OUTLINE_FEATURE;

    assign last_col_s  = (out_x_q == xmax_q);
    assign last_pix_s  = last_col_s && (out_y_q == ymax_q);
    assign next_x_s    = last_col_s ? xmin_q : (out_x_q + 8'd1);
    assign next_y_s    = last_col_s ? (out_y_q + 8'd1) : out_y_q;

    // Next-state and output-register computation for the command FSM.
    always_comb begin
        state_d   = state_q;
        cmd_x0_d  = cmd_x0_q;
        cmd_y0_d  = cmd_y0_q;
        cmd_x1_d  = cmd_x1_q;
        cmd_y1_d  = cmd_y1_q;
        colour_d  = colour_q;
        outline_d = outline_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_rgb_d = out_rgb_q;
        out_wr_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d   = ST_SETUP;
                    busy_d    = 1'b1;
                    cmd_x0_d  = bus.X0;
                    cmd_y0_d  = bus.Y0;
                    cmd_x1_d  = bus.X1;
                    cmd_y1_d  = bus.Y1;
                    colour_d  = bus.COLOUR;
                    outline_d = bus.OUTLINE;
                end else begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                end
            end

            ST_SETUP: begin
                xmin_d = norm_xmin_s;
                xmax_d = clip_xmax_s;
                ymin_d = norm_ymin_s;
                ymax_d = clip_ymax_s;
                if (empty_s) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Preload the first pixel so the write appears on the first SCAN cycle.
                    state_d   = ST_SCAN;
                    out_x_d   = norm_xmin_s;
                    out_y_d   = norm_ymin_s;
                    out_rgb_d = colour_q;
                    out_wr_d  = !mask_en_s ||
                                on_border(norm_xmin_s, norm_ymin_s, norm_xmin_s,
                                          clip_xmax_s, norm_ymin_s, clip_ymax_s);
                end
            end

            ST_SCAN: begin
                if (last_pix_s) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    out_x_d  = next_x_s;
                    out_y_d  = next_y_s;
                    out_wr_d = !mask_en_s ||
                               on_border(next_x_s, next_y_s, xmin_q, xmax_q, ymin_q, ymax_q);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cmd_x0_q  <= 8'd0;
            cmd_y0_q  <= 8'd0;
            cmd_x1_q  <= 8'd0;
            cmd_y1_q  <= 8'd0;
            colour_q  <= 12'd0;
            outline_q <= 1'b0;
            xmin_q    <= 8'd0;
            xmax_q    <= 8'd0;
            ymin_q    <= 8'd0;
            ymax_q    <= 8'd0;
            out_x_q   <= 8'd0;
            out_y_q   <= 8'd0;
            out_rgb_q <= 12'd0;
            out_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_x0_q  <= cmd_x0_d;
            cmd_y0_q  <= cmd_y0_d;
            cmd_x1_q  <= cmd_x1_d;
            cmd_y1_q  <= cmd_y1_d;
            colour_q  <= colour_d;
            outline_q <= outline_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_rgb_q <= out_rgb_d;
            out_wr_q  <= out_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.OUT_X   = out_x_q;
    assign bus.OUT_Y   = out_y_q;
    assign bus.OUT_WR  = out_wr_q;
    assign bus.OUT_RGB = out_rgb_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed and random rectangles against a pixel-list model.
module tb_rect_fill_engine;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

`ifdef RECT_OUTLINE_EN
    localparam bit OUTLINE_BUILT = 1'b1;
`else
    localparam bit OUTLINE_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    rect_fill_engine_if bus();

    rect_fill_engine #(.SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
        .CLOCK_25 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int x;
        int y;
        bit wr;
    } pix_t;

    pix_t        pq[$];
    int          checks = 0;
    int          passed = 0;
    int          hold_x = 0;
    int          hold_y = 0;
    int          hold_rgb = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Expected write list: every pixel of the clipped rectangle in raster order.
    task automatic build_model(input int x0, input int y0, input int x1, input int y1, input bit ol);
        int xmin, xmax, ymin, ymax;
        bit border;
        pq.delete();
        xmin = (x0 < x1) ? x0 : x1;
        xmax = (x0 < x1) ? x1 : x0;
        ymin = (y0 < y1) ? y0 : y1;
        ymax = (y0 < y1) ? y1 : y0;
        if (xmin >= SCR_W || ymin >= SCR_H) return;
        if (xmax > SCR_W - 1) xmax = SCR_W - 1;
        if (ymax > SCR_H - 1) ymax = SCR_H - 1;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                border = (x == xmin) || (x == xmax) || (y == ymin) || (y == ymax);
                pq.push_back('{x: x, y: y, wr: (!(ol && OUTLINE_BUILT)) || border});
            end
        end
    endtask

    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                           input int col, input bit ol, input bit pulse, input int abort_at);
        int   n;
        int   done_k;
        pix_t p;
        build_model(x0, y0, x1, y1, ol);
        n      = pq.size();
        done_k = 2 + n;
        @(negedge clk);
        bus.START   = 1'b1;
        bus.X0      = x0[7:0];
        bus.Y0      = y0[7:0];
        bus.X1      = x1[7:0];
        bus.Y1      = y1[7:0];
        bus.COLOUR  = col[11:0];
        bus.OUTLINE = ol;
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            bus.START   = pulse && (k < done_k);
            bus.X0      = 8'($urandom);
            bus.Y0      = 8'($urandom);
            bus.X1      = 8'($urandom);
            bus.Y1      = 8'($urandom);
            bus.COLOUR  = 12'($urandom);
            bus.OUTLINE = 1'($urandom);
            chk("busy", bus.BUSY, k < done_k);
            chk("done", bus.DONE, k == done_k);
            if (k >= 2 && k <= 1 + n) begin
                p = pq[k - 2];
                chk("wr", bus.OUT_WR, p.wr);
                if (p.wr) begin
                    chk("x", bus.OUT_X, p.x);
                    chk("y", bus.OUT_Y, p.y);
                    chk("rgb", bus.OUT_RGB, col);
                end
                hold_x   = p.x;
                hold_y   = p.y;
                hold_rgb = col;
            end else begin
                chk("wr_idle", bus.OUT_WR, 1'b0);
            end
            if (k == done_k) begin
                chk("hold_x", bus.OUT_X, hold_x);
                chk("hold_y", bus.OUT_Y, hold_y);
                chk("hold_rgb", bus.OUT_RGB, hold_rgb);
            end
            if (abort_at >= 0 && k == 2 + abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                bus.START = 1'b0;
                chk("rst_busy", bus.BUSY, 1'b0);
                chk("rst_done", bus.DONE, 1'b0);
                chk("rst_wr", bus.OUT_WR, 1'b0);
                chk("rst_x", bus.OUT_X, 8'd0);
                chk("rst_y", bus.OUT_Y, 8'd0);
                chk("rst_rgb", bus.OUT_RGB, 12'd0);
                hold_x = 0;
                hold_y = 0;
                hold_rgb = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        bus.START = 1'b0;
        @(negedge clk);
        chk("post_busy", bus.BUSY, 1'b0);
        chk("post_done", bus.DONE, 1'b0);
        chk("post_wr", bus.OUT_WR, 1'b0);
        if (pulse) begin
            @(negedge clk);
            chk("no_restart", bus.BUSY, 1'b0);
        end
    endtask

    initial begin
        int rx0, ry0, rx1, ry1, lo;
        bus.START   = 1'b0;
        bus.X0      = 8'd0;
        bus.Y0      = 8'd0;
        bus.X1      = 8'd0;
        bus.Y1      = 8'd0;
        bus.COLOUR  = 12'd0;
        bus.OUTLINE = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_busy", bus.BUSY, 1'b0);
        chk("init_done", bus.DONE, 1'b0);
        chk("init_wr", bus.OUT_WR, 1'b0);
        chk("init_x", bus.OUT_X, 8'd0);
        chk("init_y", bus.OUT_Y, 8'd0);
        chk("init_rgb", bus.OUT_RGB, 12'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(2, 3, 4, 4, 12'hF00, 1'b0, 1'b0, -1);
        run_cmd(150, 110, 140, 100, 12'h0A5, 1'b0, 1'b0, -1);
        run_cmd(155, 115, 255, 255, 12'h123, 1'b0, 1'b0, -1);
        run_cmd(200, 10, 210, 20, 12'h456, 1'b0, 1'b0, -1);
        run_cmd(0, 0, 159, 119, 12'h789, 1'b0, 1'b1, -1);
        run_cmd(0, 0, 159, 119, 12'hABC, 1'b0, 1'b0, 50);
        run_cmd(0, 0, 0, 0, 12'hFFF, 1'b0, 1'b0, -1);
        run_cmd(10, 10, 13, 12, 12'h0F0, 1'b1, 1'b0, -1);
        run_cmd(7, 9, 7, 5, 12'h00F, 1'b1, 1'b0, -1);

        for (int i = 0; i < 20; i++) begin
            rx0 = $urandom_range(175, 0);
            lo  = (rx0 > 8) ? rx0 - 8 : 0;
            rx1 = $urandom_range(rx0 + 8, lo);
            if (rx1 > 255) rx1 = 255;
            ry0 = $urandom_range(130, 0);
            lo  = (ry0 > 8) ? ry0 - 8 : 0;
            ry1 = $urandom_range(ry0 + 8, lo);
            run_cmd(rx0, ry0, rx1, ry1, $urandom_range(4095, 0), 1'($urandom), 1'b0, -1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
